// File: rtl/falling_box_pkg.sv
// Shared types, colour table and helpers for the falling box generator.
// Imported by falling_box_gen and box_mover.
package falling_box_pkg;

  typedef logic [5:0] rgb_t;

  localparam rgb_t BG_MID  = 6'b000011;
  localparam rgb_t BG_SIDE = 6'b110001;
  localparam int   MAX_BOXES = 8;

  function automatic rgb_t box_color(
    input logic [2:0] idx
  );
    rgb_t c;
    unique case (idx)
      3'd0: c = 6'b110100;
      3'd1: c = 6'b000100;
      3'd2: c = 6'b101101;
      3'd3: c = 6'b100101;
      3'd4: c = 6'b111000;
      3'd5: c = 6'b001111;
      3'd6: c = 6'b110011;
      3'd7: c = 6'b010110;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Starting row of box idx: boxes spread evenly over the screen height.
  function automatic logic [9:0] init_row(
    input int idx,
    input int n,
    input int h
  );
    return 10'((idx * h) / n);
  endfunction

endpackage

// File: rtl/box_mover.sv
// One scrolling box: vertical position register with restart/pause/step/wrap,
// and a combinational hit test of the current scan position against the box.
// Ports: CLK, RST (async, high), tick, restart, pause, dir_up, speed,
//        Row, Col (scan position), hit (scan position lies inside this box).
module box_mover
  import falling_box_pkg::*;
#(
  parameter int SCREEN_H = 480,
  parameter int BOX_X0   = 51,
  parameter int BOX_X1   = 162,
  parameter int BOX_H    = 50,
  parameter int INIT_Y   = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       tick,
  input  logic       restart,
  input  logic       pause,
  input  logic       dir_up,
  input  logic [1:0] speed,
  input  logic [9:0] Row,
  input  logic [9:0] Col,
  output logic       hit
);

  localparam logic [9:0]  Y0   = 10'(INIT_Y);
  localparam logic [10:0] H11  = 11'(SCREEN_H);
  localparam logic [10:0] X0   = 11'(BOX_X0);
  localparam logic [10:0] X1   = 11'(BOX_X1);
  localparam logic [10:0] BH11 = 11'(BOX_H);

  logic [9:0]  y;
  logic [10:0] yw;
  logic [10:0] step;
  logic [10:0] n_dn;
  logic [10:0] y_dn;
  logic [10:0] y_up;
  logic [10:0] row11;
  logic [10:0] col11;

  // 11-bit arithmetic keeps y+step and y+SCREEN_H clear of overflow.
  always_comb begin
    yw   = {1'b0, y};
    step = {9'd0, speed} + 11'd1;
    n_dn = yw + step;
    y_dn = (n_dn >= H11) ? n_dn - H11 : n_dn;
    y_up = (yw < step) ? yw + H11 - step : yw - step;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      y <= Y0;
    end else if (restart) begin
      y <= Y0;
    end else if (tick && !pause) begin
      y <= dir_up ? y_up[9:0] : y_dn[9:0];
    end
  end

  // No wrap term: a box reaching past the last row is clipped there.
  always_comb begin
    row11 = {1'b0, Row};
    col11 = {1'b0, Col};
    hit   = (col11 >= X0) && (col11 <= X1)
         && (row11 >= yw) && (row11 < yw + BH11);
  end

endmodule

// File: rtl/falling_box_gen.sv
// VGA pattern source: NUM_BOXES boxes scroll in one column band over a
// three-band background. Ports: CLK, RST, Row, Col, display_on, pause,
// dir_up, speed, restart -> rgb_patterngen (registered), frame_tick.
module falling_box_gen
  import falling_box_pkg::*;
#(
  parameter int NUM_BOXES = 4,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int FRAME_ROW = 486,
  parameter int BOX_X0    = 51,
  parameter int BOX_X1    = 162,
  parameter int BOX_H     = 50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] Row,
  input  logic [9:0] Col,
  input  logic       display_on,
  input  logic       pause,
  input  logic       dir_up,
  input  logic [1:0] speed,
  input  logic       restart,
  output logic [5:0] rgb_patterngen,
  output logic       frame_tick
);

  localparam logic [9:0]  FR10 = 10'(FRAME_ROW);
  localparam logic [10:0] W3   = 11'(SCREEN_W / 3);
  localparam logic [10:0] W23  = 11'((2 * SCREEN_W) / 3);

  logic [9:0]           row_q;
  logic [NUM_BOXES-1:0] hit;
  rgb_t                 pix;
  logic [10:0]          col11;

  // Tick on the first cycle Row sits at FRAME_ROW, however long it stays.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_q      <= '0;
      frame_tick <= 1'b0;
    end else begin
      row_q      <= Row;
      frame_tick <= (Row == FR10) && (row_q != FR10);
    end
  end

  for (genvar i = 0; i < NUM_BOXES; i++) begin : g_box
    box_mover #(
      .SCREEN_H (SCREEN_H),
      .BOX_X0   (BOX_X0),
      .BOX_X1   (BOX_X1),
      .BOX_H    (BOX_H),
      .INIT_Y   (int'(init_row(i, NUM_BOXES, SCREEN_H)))
    ) u_box (
      .CLK     (CLK),
      .RST     (RST),
      .tick    (frame_tick),
      .restart (restart),
      .pause   (pause),
      .dir_up  (dir_up),
      .speed   (speed),
      .Row     (Row),
      .Col     (Col),
      .hit     (hit[i])
    );
  end

  // Walk from the highest index down so the lowest hit box wins.
  always_comb begin
    col11 = {1'b0, Col};
    pix   = BG_SIDE;
    if ((col11 >= W3) && (col11 < W23)) begin
      pix = BG_MID;
    end
    for (int i = NUM_BOXES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        pix = box_color(3'(i));
      end
    end
    if (!display_on) begin
      pix = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rgb_patterngen <= '0;
    end else begin
      rgb_patterngen <= pix;
    end
  end

endmodule

// File: tb/tb_falling_box_gen.sv
// Self-checking bench for falling_box_gen: per-cycle model compare
// plus directed probes with literal expected pixels.
module tb_falling_box_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [9:0] Row = '0;
  logic [9:0] Col = '0;
  logic       display_on = 1'b0;
  logic       pause = 1'b0;
  logic       dir_up = 1'b0;
  logic [1:0] speed = 2'd0;
  logic       restart = 1'b0;
  logic [5:0] rgb;
  logic       tick;
  logic [5:0] rgb2;
  logic       tick2;

  int n_asr  = 0;
  int n_fail = 0;
  int pulses = 0;

  logic [5:0] colors [8] = '{6'b110100, 6'b000100, 6'b101101,
    6'b100101, 6'b111000, 6'b001111, 6'b110011, 6'b010110};

  int         my [4] = '{0, 120, 240, 360};
  logic       m_tick = 1'b0;
  int         m_prev = 0;
  logic [5:0] e_rgb  = '0;
  logic [5:0] e_rgb2 = '0;

  falling_box_gen dut (
    .CLK (CLK), .RST (RST), .Row (Row), .Col (Col),
    .display_on (display_on), .pause (pause), .dir_up (dir_up),
    .speed (speed), .restart (restart),
    .rgb_patterngen (rgb), .frame_tick (tick)
  );

  falling_box_gen #(.BOX_H(150)) dut_tall (
    .CLK (CLK), .RST (RST), .Row (Row), .Col (Col),
    .display_on (display_on), .pause (pause), .dir_up (dir_up),
    .speed (speed), .restart (restart),
    .rgb_patterngen (rgb2), .frame_tick (tick2)
  );

  always #5 CLK = ~CLK;

  function automatic logic [5:0] model_pix(
    input int r, input int c, input logic de, input int bh
  );
    if (!de) return 6'b000000;
    for (int i = 0; i < 4; i++)
      if (c >= 51 && c <= 162 && r >= my[i] && r < my[i] + bh)
        return colors[i];
    if (c >= 213 && c < 426) return 6'b000011;
    return 6'b110001;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) my[i] <= i * 120;
      m_tick <= 1'b0;
      m_prev <= 0;
      e_rgb  <= '0;
      e_rgb2 <= '0;
    end else begin
      e_rgb  <= model_pix(int'(Row), int'(Col), display_on, 50);
      e_rgb2 <= model_pix(int'(Row), int'(Col), display_on, 150);
      if (restart) begin
        for (int i = 0; i < 4; i++) my[i] <= i * 120;
      end else if (m_tick && !pause) begin
        for (int i = 0; i < 4; i++)
          my[i] <= dir_up ? (my[i] - (speed + 1) + 480) % 480
                          : (my[i] + speed + 1) % 480;
      end
      m_tick <= (int'(Row) == 486) && (m_prev != 486);
      m_prev <= int'(Row);
    end
  end

  always @(negedge CLK) begin
    if (tick) pulses++;
    n_asr += 3;
    if (rgb !== e_rgb) begin
      n_fail++;
      $display("FAIL model_rgb t=%0t got %b want %b", $time, rgb, e_rgb);
    end
    if (rgb2 !== e_rgb2) begin
      n_fail++;
      $display("FAIL model_rgb_tall t=%0t got %b want %b", $time, rgb2, e_rgb2);
    end
    if (tick !== m_tick) begin
      n_fail++;
      $display("FAIL model_tick t=%0t got %b want %b", $time, tick, m_tick);
    end
  end

  task automatic check6(input string nm, input logic [5:0] got, input logic [5:0] want);
    n_asr++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %b want %b", nm, got, want);
    end
  endtask

  task automatic probe(input string nm, input int r, input int c, input logic [5:0] want);
    Row = 10'(r);
    Col = 10'(c);
    @(negedge CLK);
    check6(nm, rgb, want);
  endtask

  task automatic do_tick();
    Row = 10'd486;
    @(negedge CLK);
    Row = 10'd300;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_restart();
    Row = 10'd300;
    restart = 1'b1;
    @(negedge CLK);
    restart = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    int p0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    display_on = 1'b1;
    probe("mid_band", 200, 300, 6'b000011);
    RST = 1'b1;
    #1;
    check6("async_rst_rgb", rgb, 6'b000000);
    check6("async_rst_tick", {5'd0, tick}, 6'd0);
    @(negedge CLK);
    RST = 1'b0;
    probe("rst_first_pix", 10, 100, 6'b110100);
    probe("rst_box1", 125, 100, 6'b000100);
    probe("side_band", 300, 500, 6'b110001);
    Row = 10'd130;
    Col = 10'd100;
    @(negedge CLK);
    check6("overlap_prio", rgb2, 6'b110100);
    Row = 10'd200;
    @(negedge CLK);
    check6("box1_alone", rgb2, 6'b000100);
    display_on = 1'b0;
    @(negedge CLK);
    check6("blank", rgb, 6'b000000);
    check6("blank_tall", rgb2, 6'b000000);
    display_on = 1'b1;

    p0 = pulses;
    Row = 10'd486;
    repeat (800) @(negedge CLK);
    Row = 10'd300;
    repeat (2) @(negedge CLK);
    n_asr++;
    if (pulses - p0 != 1) begin
      n_fail++;
      $display("FAIL hold_pulses got %0d want 1", pulses - p0);
    end
    probe("hold_row0", 0, 100, 6'b110001);
    probe("hold_row1", 1, 100, 6'b110100);
    probe("hold_row50", 50, 100, 6'b110100);
    probe("hold_row51", 51, 100, 6'b110001);

    do_restart();
    speed = 2'd3;
    repeat (29) do_tick();
    probe("dn_476", 476, 100, 6'b100101);
    probe("dn_475", 475, 100, 6'b110001);
    do_tick();
    probe("wrap_row0", 0, 100, 6'b100101);
    probe("wrap_row479", 479, 100, 6'b110001);

    do_restart();
    speed = 2'd1;
    do_tick();
    speed = 2'd3;
    dir_up = 1'b1;
    do_tick();
    probe("up_478", 478, 100, 6'b110100);
    probe("up_477", 477, 100, 6'b110001);
    probe("clip_row0", 0, 100, 6'b110001);
    probe("clip_row479", 479, 100, 6'b110100);

    pause = 1'b1;
    repeat (3) do_tick();
    probe("pause_478", 478, 100, 6'b110100);
    probe("pause_477", 477, 100, 6'b110001);

    Row = 10'd486;
    @(negedge CLK);
    Row = 10'd300;
    restart = 1'b1;
    @(negedge CLK);
    restart = 1'b0;
    pause = 1'b0;
    @(negedge CLK);
    probe("rs_row0", 0, 100, 6'b110100);
    probe("rs_row120", 120, 100, 6'b000100);
    probe("rs_row119", 119, 100, 6'b110001);
    repeat (2) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
    $finish;
  end

endmodule
